// File: rtl/data_sram_axi_adapter_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 data-port adapter.
package data_sram_axi_adapter_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdAr,
    StRdR,
    StWrReq,
    StWrB,
    StResp
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Tie-off values applied by the SoC top for single-beat transfers.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  function automatic logic [3:0] size_addr_to_wstrb(input logic [1:0] size,
                                                    input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << {addr_lo[1], 1'b0};
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/data_sram_axi_adapter_if.sv
// SRAM-like data port plus AXI3 single-beat channels; master is the adapter view.
interface data_sram_axi_adapter_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              wrap_data_req;
  logic              wrap_data_wr;
  logic [1:0]        wrap_data_size;
  logic [ADDR_W-1:0] wrap_data_addr;
  logic [31:0]       wrap_data_wdata;
  logic [31:0]       wrap_data_rdata;
  logic              wrap_data_addr_ok;
  logic              wrap_data_data_ok;

  logic [ADDR_W-1:0] axi_araddr;
  logic [2:0]        axi_arsize;
  logic              axi_arvalid;
  logic              axi_arready;
  logic [31:0]       axi_rdata;
  logic              axi_rvalid;
  logic              axi_rready;
  logic [ADDR_W-1:0] axi_awaddr;
  logic [2:0]        axi_awsize;
  logic              axi_awvalid;
  logic              axi_awready;
  logic [31:0]       axi_wdata;
  logic [3:0]        axi_wstrb;
  logic              axi_wvalid;
  logic              axi_wready;
  logic              axi_bvalid;
  logic              axi_bready;

  modport master (
    input  wrap_data_req, wrap_data_wr, wrap_data_size, wrap_data_addr, wrap_data_wdata,
    output wrap_data_rdata, wrap_data_addr_ok, wrap_data_data_ok,
    output axi_araddr, axi_arsize, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rvalid,
    output axi_awaddr, axi_awsize, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_awready, axi_wready, axi_bvalid
  );

  modport slave (
    output wrap_data_req, wrap_data_wr, wrap_data_size, wrap_data_addr, wrap_data_wdata,
    input  wrap_data_rdata, wrap_data_addr_ok, wrap_data_data_ok,
    input  axi_araddr, axi_arsize, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rvalid,
    input  axi_awaddr, axi_awsize, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_awready, axi_wready, axi_bvalid
  );

endinterface

// File: rtl/data_sram_axi_adapter.sv
// Converts the SRAM-like data port into single-beat AXI3 reads/writes,
// one outstanding transaction at a time.
module data_sram_axi_adapter
  import data_sram_axi_adapter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  data_sram_axi_adapter_if.master bus_io
);

  state_e            state_q, state_d;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       rdata_q, rdata_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic addr_ok, data_ok;
  logic arvalid, rready, awvalid, wvalid, bready;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_ok = bus_io.wrap_data_req & ~rst;
        if (addr_ok) begin
          state_d = bus_io.wrap_data_wr ? StWrReq : StRdAr;
        end
      end
      StRdAr: begin
        arvalid = 1'b1;
        if (bus_io.axi_arready) begin
          state_d = StRdR;
        end
      end
      StRdR: begin
        rready = 1'b1;
        if (bus_io.axi_rvalid) begin
          rdata_d = bus_io.axi_rdata;
          state_d = StResp;
        end
      end
      StWrReq: begin
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & bus_io.axi_awready);
        w_done_d  = w_done_q | (wvalid & bus_io.axi_wready);
        // Leave as soon as both handshakes are in, counting this cycle's.
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        bready = 1'b1;
        if (bus_io.axi_bvalid) begin
          state_d = StResp;
        end
      end
      StResp: begin
        data_ok = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      size_q    <= 2'd0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (addr_ok) begin
        size_q  <= bus_io.wrap_data_size;
        addr_q  <= bus_io.wrap_data_addr;
        wdata_q <= bus_io.wrap_data_wdata;
        wstrb_q <= size_addr_to_wstrb(bus_io.wrap_data_size, bus_io.wrap_data_addr[1:0]);
      end
    end
  end

  assign bus_io.wrap_data_rdata   = rdata_q;
  assign bus_io.wrap_data_addr_ok = addr_ok;
  assign bus_io.wrap_data_data_ok = data_ok;

  assign bus_io.axi_araddr  = addr_q;
  assign bus_io.axi_arsize  = {1'b0, size_q};
  assign bus_io.axi_arvalid = arvalid;
  assign bus_io.axi_rready  = rready;
  assign bus_io.axi_awaddr  = addr_q;
  assign bus_io.axi_awsize  = {1'b0, size_q};
  assign bus_io.axi_awvalid = awvalid;
  assign bus_io.axi_wdata   = wdata_q;
  assign bus_io.axi_wstrb   = wstrb_q;
  assign bus_io.axi_wvalid  = wvalid;
  assign bus_io.axi_bready  = bready;

endmodule

// File: tb/tb_data_sram_axi_adapter.sv
// Self-checking bench for data_sram_axi_adapter: vector table plus scoreboard
// queues, with hand-written latency, wait-state and reset sequences.
module tb_data_sram_axi_adapter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  data_sram_axi_adapter_if #(.ADDR_W(32)) bus ();

  data_sram_axi_adapter #(.ADDR_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rsp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    logic [3:0]  strb;
    logic [2:0]  axsize;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic wr, logic [1:0] size, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rsp, int ar_dly,
                              int aw_dly, int w_dly, logic [3:0] strb,
                              logic [2:0] axsize, logic [31:0] rdata);
    vec_t v;
    v.wr = wr; v.size = size; v.addr = addr; v.wdata = wdata; v.rsp = rsp;
    v.ar_dly = ar_dly; v.aw_dly = aw_dly; v.w_dly = w_dly;
    v.strb = strb; v.axsize = axsize; v.rdata = rdata;
    return v;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {bus.wrap_data_rdata, bus.wrap_data_addr_ok, bus.wrap_data_data_ok,
            bus.axi_araddr, bus.axi_arsize, bus.axi_arvalid, bus.axi_rready,
            bus.axi_awaddr, bus.axi_awsize, bus.axi_awvalid, bus.axi_wdata,
            bus.axi_wstrb, bus.axi_wvalid, bus.axi_bready};
  endfunction

  vec_t exp_ar[$];
  vec_t exp_aw[$];
  vec_t exp_w[$];
  vec_t exp_rsp[$];
  bit   outstanding = 1'b0;
  int   last_dok_cyc = 0;
  int   accept_cyc = 0;

  // Slave configuration, loaded when a request is accepted.
  int          cfg_ar = 0, cfg_aw = 0, cfg_w = 0;
  logic [31:0] cfg_rsp = 32'd0;

  // AXI slave: ready after N valid cycles; R and B valid always high so that
  // responses outside the expected state must be ignored by the DUT.
  initial begin
    int ar_cnt, aw_cnt, w_cnt;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    bus.axi_arready = 1'b0; bus.axi_awready = 1'b0; bus.axi_wready = 1'b0;
    bus.axi_rvalid  = 1'b1; bus.axi_bvalid  = 1'b1; bus.axi_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (bus.axi_arvalid) begin bus.axi_arready = (ar_cnt >= cfg_ar); ar_cnt++; end
      else begin bus.axi_arready = 1'b0; ar_cnt = 0; end
      if (bus.axi_awvalid) begin bus.axi_awready = (aw_cnt >= cfg_aw); aw_cnt++; end
      else begin bus.axi_awready = 1'b0; aw_cnt = 0; end
      if (bus.axi_wvalid) begin bus.axi_wready = (w_cnt >= cfg_w); w_cnt++; end
      else begin bus.axi_wready = 1'b0; w_cnt = 0; end
      bus.axi_rdata = bus.axi_rready ? cfg_rsp : ~cfg_rsp;
    end
  end

  // Scoreboard monitor.
  initial begin
    vec_t        e;
    bit          p_arv, p_awv, p_wv;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize, p_awsize;
    logic [3:0]  p_wstrb;
    p_arv = 0; p_awv = 0; p_wv = 0;
    p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_arsize = 0; p_awsize = 0; p_wstrb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (p_arv) chk("ar_stable", {bus.axi_arvalid, bus.axi_araddr, bus.axi_arsize},
                       {1'b1, p_araddr, p_arsize});
        if (p_awv) chk("aw_stable", {bus.axi_awvalid, bus.axi_awaddr, bus.axi_awsize},
                       {1'b1, p_awaddr, p_awsize});
        if (p_wv) chk("w_stable", {bus.axi_wvalid, bus.axi_wdata, bus.axi_wstrb},
                      {1'b1, p_wdata, p_wstrb});
        if (bus.axi_arvalid && bus.axi_arready) begin
          chk("ar_expected", exp_ar.size(), 1);
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            chk("araddr", bus.axi_araddr, e.addr);
            chk("arsize", bus.axi_arsize, e.axsize);
          end
        end
        if (bus.axi_awvalid && bus.axi_awready) begin
          chk("aw_expected", exp_aw.size(), 1);
          if (exp_aw.size() != 0) begin
            e = exp_aw.pop_front();
            chk("awaddr", bus.axi_awaddr, e.addr);
            chk("awsize", bus.axi_awsize, e.axsize);
          end
        end
        if (bus.axi_wvalid && bus.axi_wready) begin
          chk("w_expected", exp_w.size(), 1);
          if (exp_w.size() != 0) begin
            e = exp_w.pop_front();
            chk("wdata", bus.axi_wdata, e.wdata);
            chk("wstrb", bus.axi_wstrb, e.strb);
          end
        end
        if (bus.wrap_data_data_ok) begin
          chk("rsp_expected", exp_rsp.size(), 1);
          if (exp_rsp.size() != 0) begin
            e = exp_rsp.pop_front();
            chk("rdata", bus.wrap_data_rdata, e.rdata);
          end
          chk("phases_done", exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
          outstanding  = 1'b0;
          last_dok_cyc = cyc;
        end
        if (bus.wrap_data_addr_ok) begin
          chk("no_overlap", outstanding, 0);
          outstanding = 1'b1;
        end
        p_arv = bus.axi_arvalid && !bus.axi_arready;
        p_awv = bus.axi_awvalid && !bus.axi_awready;
        p_wv  = bus.axi_wvalid && !bus.axi_wready;
        p_araddr = bus.axi_araddr; p_arsize = bus.axi_arsize;
        p_awaddr = bus.axi_awaddr; p_awsize = bus.axi_awsize;
        p_wdata  = bus.axi_wdata;  p_wstrb  = bus.axi_wstrb;
      end
    end
  end

  // Called just after a posedge; returns at the negedge where addr_ok is seen.
  task automatic issue(input vec_t v);
    bit ok;
    bus.wrap_data_req   = 1'b1;
    bus.wrap_data_wr    = v.wr;
    bus.wrap_data_size  = v.size;
    bus.wrap_data_addr  = v.addr;
    bus.wrap_data_wdata = v.wdata;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.wrap_data_addr_ok) ok = 1'b1;
    end
    chk("accept", ok, 1);
    if (ok) begin
      accept_cyc = cyc;
      cfg_ar = v.ar_dly; cfg_aw = v.aw_dly; cfg_w = v.w_dly; cfg_rsp = v.rsp;
      if (v.wr) begin exp_aw.push_back(v); exp_w.push_back(v); end
      else exp_ar.push_back(v);
      exp_rsp.push_back(v);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (outstanding && n < 100) begin @(negedge clk); n++; end
    chk("completion", outstanding, 0);
    outstanding = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[10];
  int   t0;

  initial begin
    bus.wrap_data_req = 1'b0; bus.wrap_data_wr = 1'b0; bus.wrap_data_size = 2'd0;
    bus.wrap_data_addr = 32'd0; bus.wrap_data_wdata = 32'd0;

    //         wr size addr           wdata          rsp        ar aw w  strb   axsz    rdata
    tbl[0] = mk(0, 2, 32'h1FC0_0010, 32'h0,        32'hDEADBEEF, 0, 0, 0, 4'h0, 3'b010, 32'hDEADBEEF);
    tbl[1] = mk(1, 0, 32'h8000_0003, 32'h1111_1111, 32'h0,       0, 0, 3, 4'h8, 3'b000, 32'hDEADBEEF);
    tbl[2] = mk(1, 1, 32'h8000_0002, 32'h2222_2222, 32'h0,       0, 1, 0, 4'hC, 3'b001, 32'hDEADBEEF);
    tbl[3] = mk(1, 3, 32'h8000_0004, 32'h3333_3333, 32'h0,       0, 2, 0, 4'hF, 3'b011, 32'hDEADBEEF);
    tbl[4] = mk(0, 0, 32'h0000_0005, 32'h0,        32'h12345678, 2, 0, 0, 4'h0, 3'b000, 32'h12345678);
    tbl[5] = mk(1, 0, 32'h0000_0001, 32'hAAAA_AAAA, 32'h0,       0, 0, 0, 4'h2, 3'b000, 32'h12345678);
    tbl[6] = mk(1, 1, 32'h0000_0000, 32'hBBBB_BBBB, 32'h0,       0, 0, 2, 4'h3, 3'b001, 32'h12345678);
    tbl[7] = mk(0, 1, 32'h0000_000A, 32'h0,        32'hCAFEF00D, 5, 0, 0, 4'h0, 3'b001, 32'hCAFEF00D);
    tbl[8] = mk(1, 2, 32'h0000_1000, 32'hCCCC_CCCC, 32'h0,       0, 3, 1, 4'hF, 3'b010, 32'hCAFEF00D);
    tbl[9] = mk(1, 0, 32'h0000_0002, 32'hDDDD_DDDD, 32'h0,       0, 0, 0, 4'h4, 3'b000, 32'hCAFEF00D);

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Vector table with req held high throughout: back-to-back acceptance.
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i]);
      if (i > 0) chk("b2b_gap", accept_cyc - last_dok_cyc, 1);
      @(posedge clk); #1;
    end
    bus.wrap_data_req = 1'b0;
    wait_idle();

    // Minimum read latency, with req dropped right after acceptance.
    t0 = cyc;
    issue(mk(0, 2, 32'h1FC0_0010, 0, 32'hDEADBEEF, 0, 0, 0, 4'h0, 3'b010, 32'hDEADBEEF));
    chk("rd_accept_c0", accept_cyc - t0, 0);
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    @(negedge clk);
    chk("rd_c1", {bus.axi_arvalid, bus.axi_rready, bus.axi_araddr, bus.axi_arsize},
        {1'b1, 1'b0, 32'h1FC0_0010, 3'b010});
    @(negedge clk);
    chk("rd_c2", {bus.axi_arvalid, bus.axi_rready, bus.wrap_data_data_ok}, 3'b010);
    @(negedge clk);
    chk("rd_c3", {bus.wrap_data_data_ok, bus.wrap_data_rdata}, {1'b1, 32'hDEADBEEF});
    wait_idle();

    // Minimum write latency.
    issue(mk(1, 2, 32'h2000_0000, 32'h0BAD_CAFE, 0, 0, 0, 0, 4'hF, 3'b010, 32'hDEADBEEF));
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    @(negedge clk);
    chk("wr_c1", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_awaddr, bus.axi_wdata,
                  bus.axi_wstrb}, {2'b11, 32'h2000_0000, 32'h0BAD_CAFE, 4'hF});
    @(negedge clk);
    chk("wr_c2", {bus.axi_awvalid, bus.axi_wvalid, bus.axi_bready, bus.wrap_data_data_ok},
        4'b0010);
    @(negedge clk);
    chk("wr_c3", {bus.wrap_data_data_ok, bus.wrap_data_rdata}, {1'b1, 32'hDEADBEEF});
    wait_idle();

    // AR stalled 5 cycles while a second request waits upstream.
    issue(mk(0, 1, 32'h3000_0006, 0, 32'h0F0F_0F0F, 5, 0, 0, 4'h0, 3'b001, 32'h0F0F_0F0F));
    @(posedge clk); #1;
    bus.wrap_data_addr = 32'h3000_0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("ar_wait", {bus.wrap_data_addr_ok, bus.axi_arvalid, bus.axi_araddr},
          {2'b01, 32'h3000_0006});
    end
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    wait_idle();

    // Reset in WR_REQ after AW has completed but W is still pending.
    issue(mk(1, 2, 32'h0000_0040, 32'h5555_5555, 0, 0, 0, 10, 4'hF, 3'b010, 32'h0F0F_0F0F));
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_aw_done", {bus.axi_awvalid, bus.axi_wvalid}, 2'b01);
    rst = 1'b1;
    exp_ar.delete(); exp_aw.delete(); exp_w.delete(); exp_rsp.delete();
    outstanding = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), 0);
    @(negedge clk);
    chk("rst_held_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(mk(1, 1, 32'h0000_0044, 32'h6666_6666, 0, 0, 0, 0, 4'h3, 3'b001, 32'h0));
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    wait_idle();
    issue(mk(0, 0, 32'h0000_0047, 0, 32'hA5A5_A5A5, 1, 0, 0, 4'h0, 3'b000, 32'hA5A5_A5A5));
    @(posedge clk); #1;
    bus.wrap_data_req = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_sram_axi_adapter.md
Name: data_sram_axi_adapter

Overview:
- Converts the single SRAM-like data port (wrap_data_*) into AXI3 single-beat read/write transactions.
- Sits directly downstream of the cached/uncached data-port mux, and upstream of the AXI crossbar.
- Allows one outstanding transaction at a time: accept, issue on AXI, await response, report data_ok, then accept the next.

Parameters:
ADDR_W, 32, width of wrap_data_addr and axi_araddr/axi_awaddr

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
wrap_data_req  in  1  request valid
wrap_data_wr  in  1  1=write, 0=read
wrap_data_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
wrap_data_addr  in  ADDR_W  byte address
wrap_data_wdata  in  32  write data, already lane-replicated by the CPU
wrap_data_rdata  out  32  registered read data, valid when data_ok
wrap_data_addr_ok  out  1  request accepted this cycle
wrap_data_data_ok  out  1  one-cycle completion pulse
axi_araddr  out  ADDR_W  read address
axi_arsize  out  3  {1'b0, size}
axi_arvalid  out  1  AR valid
axi_arready  in  1  AR ready
axi_rdata  in  32  read data
axi_rvalid  in  1  R valid
axi_rready  out  1  R ready
axi_awaddr  out  ADDR_W  write address
axi_awsize  out  3  {1'b0, size}
axi_awvalid  out  1  AW valid
axi_awready  in  1  AW ready
axi_wdata  out  32  write data
axi_wstrb  out  4  byte strobes
axi_wvalid  out  1  W valid
axi_wready  in  1  W ready
axi_bvalid  in  1  B valid
axi_bready  out  1  B ready
- The SoC top ties off ID, len=0, burst=INCR, wlast=1, lock, cache and prot. The resp fields are not consumed.

Behaviour:
- Reset values:
  - All outputs are 0 and rdata=0.
  - State=IDLE; aw_done=w_done=0.
- States: IDLE, RD_AR, RD_R, WR_REQ, WR_B, RESP.
- addr_ok is combinational: (state==IDLE) & req.
  - On addr_ok, latch wr, size, addr and wdata. Compute wstrb from the latched values.
  - Next state is RD_AR if wr=0, otherwise WR_REQ.
- RD_AR: arvalid=1 with the latched address and size. On arready go to RD_R. arvalid must not drop before arready.
- RD_R: rready=1. On rvalid, register rdata := axi_rdata and go to RESP.
- WR_REQ:
  - awvalid = !aw_done and wvalid = !w_done.
  - Set aw_done on awvalid&awready, and w_done on wvalid&wready. The two handshakes are independent and may occur in either order or in the same cycle.
  - Go to WR_B in the cycle in which both are complete (counting that cycle's handshakes). Clear both flags on that transition.
- WR_B: bready=1. On bvalid go to RESP.
- RESP: data_ok=1 for exactly one cycle, then IDLE. addr_ok is never asserted in RESP, so no back-to-back overlap.
- rdata holds its last read value across writes.
- wstrb rules:
  - size0: 4'b0001<<addr[1:0].
  - size1: 4'b0011<<{addr[1],1'b0}.
  - size2/3: 4'b1111.
- Minimum read latency (accept at cycle 0, ready/valid always high):
  - arvalid at cycle 1, rready at cycle 2, data_ok at cycle 3.
- Minimum write latency: aw/w handshakes at cycle 1, bready at cycle 2, data_ok at cycle 3.
- req dropping after addr_ok has no effect; the transaction completes.
- Requests while not in IDLE see addr_ok=0 and must be held by the upstream block.
- rvalid or bvalid arriving outside RD_R/WR_B is ignored; the ready signals are low then.
- Reset mid-transaction forces IDLE and deasserts every valid and ready. The system-wide reset is responsible for AXI consistency.

Decomposition:
- Shared package holds:
  - the state enum;
  - SIZE_BYTE/HALF/WORD constants;
  - the AXI_BURST_INCR and AXI_LEN_SINGLE constants used by the top-level tie-offs;
  - the function size_addr_to_wstrb(size, addr_lo).
- Single module; no sub-module is warranted.

Test Plan:
- Read, ready/valid always high: req=1, wr=0, addr=0x1FC0_0010, size=2, rdata=0xDEADBEEF -> addr_ok at cycle 0, araddr=0x1FC00010 and arsize=3'b010 at cycle 1, data_ok with rdata=0xDEADBEEF at cycle 3.
- Byte write at addr=0x8000_0003, wdata=0x11111111, W ready delayed 3 cycles after AW -> wstrb=4'b1000; awvalid drops after awready while wvalid stays high until wready; data_ok 2 cycles after the wready handshake cycle with bvalid=1.
- Half write at addr=0x8000_0002 -> wstrb=4'b1100. Word write with size=3 -> wstrb=4'b1111 and awsize=3'b011.
- arready held low for 5 cycles -> arvalid and araddr stay stable throughout; a second req in that window gets addr_ok=0.
- Write then read back-to-back with req held high -> second addr_ok is exactly one cycle after the first data_ok; no overlap.
- rst asserted in WR_REQ with aw_done=1 -> all outputs go to 0 immediately; after release the next write performs a fresh AW and W handshake.
